// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, FSM states, control word and IR field positions for cu_sequencer
package cu_pkg;

    localparam int IR_W    = 16;

    // Instruction word field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 9;
    localparam int DR_MSB  = 8;
    localparam int DR_LSB  = 6;
    localparam int SA_MSB  = 5;
    localparam int SA_LSB  = 3;
    localparam int SB_MSB  = 2;
    localparam int SB_LSB  = 0;

    // Opcodes; register ops are the whole 000_xxxx group
    localparam logic [2:0] GRP_REG = 3'b000;
    localparam logic [6:0] OP_ADI  = 7'b100_0010;
    localparam logic [6:0] OP_LDI  = 7'b100_1100;
    localparam logic [6:0] OP_LD   = 7'b001_0000;
    localparam logic [6:0] OP_ST   = 7'b010_0000;
    localparam logic [6:0] OP_BRZ  = 7'b110_0000;
    localparam logic [6:0] OP_JMP  = 7'b111_0000;
    localparam logic [6:0] OP_HALT = 7'b111_1111;

    // Execution unit functions used by the decoder
    localparam logic [3:0] EU_MOVA = 4'b0000;
    localparam logic [3:0] EU_ADD  = 4'b0010;
    localparam logic [3:0] EU_MOVB = 4'b1100;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] rs_a;
        logic [2:0] rs_b;
        logic [2:0] rd;
        logic [2:0] constant_in;
        logic       mb;
        logic       md;
        logic [3:0] op_select;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational IR to datapath control word and instruction class flags
//   ir       : instruction register contents
//   ctrl     : control word to present during EXEC
//   is_*     : instruction class flags used by the sequencer FSM
module cu_decoder
    import cu_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output ctrl_word_t      ctrl,
    output logic            is_ld,
    output logic            is_st,
    output logic            is_brz,
    output logic            is_jmp,
    output logic            is_halt
);

    logic [6:0] opc;
    logic [2:0] dr;
    logic [2:0] sa;
    logic [2:0] sb;

    assign opc = ir[OPC_MSB:OPC_LSB];
    assign dr  = ir[DR_MSB:DR_LSB];
    assign sa  = ir[SA_MSB:SA_LSB];
    assign sb  = ir[SB_MSB:SB_LSB];

    always_comb begin
        ctrl             = CTRL_IDLE;
        ctrl.rs_a        = sa;
        ctrl.rs_b        = sb;
        ctrl.rd          = dr;
        ctrl.constant_in = sb;
        is_ld            = 1'b0;
        is_st            = 1'b0;
        is_brz           = 1'b0;
        is_jmp           = 1'b0;
        is_halt          = 1'b0;

        if (opc[6:4] == GRP_REG) begin
            ctrl.op_select = opc[3:0];
            ctrl.reg_write = 1'b1;
        end else begin
            case (opc)
                OP_ADI: begin
                    ctrl.mb        = 1'b1;
                    ctrl.op_select = EU_ADD;
                    ctrl.reg_write = 1'b1;
                end
                OP_LDI: begin
                    ctrl.mb        = 1'b1;
                    ctrl.op_select = EU_MOVB;
                    ctrl.reg_write = 1'b1;
                end
                OP_LD:   is_ld   = 1'b1;
                OP_ST:   is_st   = 1'b1;
                OP_BRZ: begin
                    // MOVA passes R[SA] through the EU so dp_zero reflects it
                    is_brz         = 1'b1;
                    ctrl.op_select = EU_MOVA;
                end
                OP_JMP:  is_jmp  = 1'b1;
                OP_HALT: is_halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - multi-cycle fetch/exec/mem/halt control unit driving dp_top
//   clk, rst                 : clock, synchronous active-high reset
//   mem_*                    : single-port memory request/ack handshake
//   regWrite..data_in        : datapath control word to dp_top
//   dp_address_out, dp_data_out, dp_zero : datapath status from dp_top
//   pc, halted               : status
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int                   BUS_WIDTH = 16,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
)(
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 regWrite,
    output logic [2:0]           rsA,
    output logic [2:0]           rsB,
    output logic [2:0]           rd,
    output logic [2:0]           constant_in,
    output logic                 MB,
    output logic                 MD,
    output logic [3:0]           op_select,
    output logic [BUS_WIDTH-1:0] data_in,
    input  logic [BUS_WIDTH-1:0] dp_address_out,
    input  logic [BUS_WIDTH-1:0] dp_data_out,
    input  logic                 dp_zero,
    output logic [BUS_WIDTH-1:0] pc,
    output logic                 halted
);

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_WIDTH-1:0] ir_q, ir_d;
    logic [BUS_WIDTH-1:0] br_off;
    ctrl_word_t           dec_ctrl, ctrl;
    logic                 is_ld, is_st, is_brz, is_jmp, is_halt;

    cu_decoder u_decoder (
        .ir      (ir_q[IR_W-1:0]),
        .ctrl    (dec_ctrl),
        .is_ld   (is_ld),
        .is_st   (is_st),
        .is_brz  (is_brz),
        .is_jmp  (is_jmp),
        .is_halt (is_halt)
    );

    // 6-bit branch offset {DR,SB}, sign-extended to the PC width
    assign br_off = {{(BUS_WIDTH-6){ir_q[DR_MSB]}}, ir_q[DR_MSB:DR_LSB], ir_q[SB_MSB:SB_LSB]};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ctrl      = CTRL_IDLE;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        data_in   = '0;

        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + BUS_WIDTH'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ctrl = dec_ctrl;
                // pc_q already points past this instruction
                if (is_brz && dp_zero) begin
                    pc_d = pc_q + br_off;
                end else if (is_jmp) begin
                    pc_d = dp_address_out;
                end
                if (is_ld || is_st) begin
                    state_d = ST_MEM;
                end else if (is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                // Selects held so the address/store data from dp_top stay stable across waits
                mem_req   = 1'b1;
                mem_addr  = dp_address_out;
                ctrl.rs_a = dec_ctrl.rs_a;
                ctrl.rs_b = dec_ctrl.rs_b;
                if (is_ld) begin
                    ctrl.md        = 1'b1;
                    ctrl.rd        = dec_ctrl.rd;
                    ctrl.reg_write = mem_ack;
                    data_in        = mem_rdata;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = dp_data_out;
                end
                if (mem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase

        // Reset suppresses any register write or memory request in flight
        if (rst) begin
            ctrl.reg_write = 1'b0;
            mem_req        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign regWrite    = ctrl.reg_write;
    assign rsA         = ctrl.rs_a;
    assign rsB         = ctrl.rs_b;
    assign rd          = ctrl.rd;
    assign constant_in = ctrl.constant_in;
    assign MB          = ctrl.mb;
    assign MD          = ctrl.md;
    assign op_select   = ctrl.op_select;
    assign pc          = pc_q;
    assign halted      = (state_q == ST_HALT);

endmodule
